uart_frame_rx: RTL and testbench

UART_FRAME_RX -- requirements
Module: uart_frame_rx

---
 rtl/uart_frame_rx.sv | 161 ++++++++++++++++
 tb/tb_uart_frame_rx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// Frame parser behind a UART receive FIFO: SYNC, LEN, LEN payload bytes, optional CSUM.
// Define FRAME_CHECKSUM_EN to compile in the checksum byte and its check (err_code 2).
module uart_frame_rx #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd,
  output logic [7:0] pay_data,
  output logic       pay_valid,
  output logic [7:0] pay_idx,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef FRAME_CHECKSUM_EN
  typedef enum logic [1:0] {HUNT = 2'd0, LEN = 2'd1, PAYLOAD = 2'd2, CSUM = 2'd3} state_e;
`else
  typedef enum logic [1:0] {HUNT = 2'd0, LEN = 2'd1, PAYLOAD = 2'd2} state_e;
`endif

  state_e          state_q, state_d;
  logic            rd_q, rd_d;
  logic            pay_valid_q, pay_valid_d;
  logic            frame_done_q, frame_done_d;
  logic            frame_err_q, frame_err_d;
  logic            busy_q, busy_d;
  logic [7:0]      pay_data_q, pay_data_d;
  logic [7:0]      pay_idx_q, pay_idx_d;
  logic [7:0]      len_q, len_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [TW-1:0]   tmo_q, tmo_d;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]      sum_q, sum_d;
`endif

  // A byte is captured on the edge that closes each one-cycle rd pulse.
  always_comb begin
    state_d      = state_q;
    rd_d         = ~rx_empty & ~rd_q;
    pay_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    pay_data_d   = pay_data_q;
    pay_idx_d    = pay_valid_q ? pay_idx_q + 8'd1 : pay_idx_q;
    len_d        = len_q;
    err_code_d   = err_code_q;
    tmo_d        = tmo_q + TW'(1);
`ifdef FRAME_CHECKSUM_EN
    sum_d        = sum_q;
`endif

    if (rd_q) begin
      tmo_d = '0;
      case (state_q)
        HUNT: begin
          if (r_data == SYNC_BYTE) state_d = LEN;
        end
        LEN: begin
          len_d = r_data;
          if (r_data == 8'd0 || 32'(r_data) > MAX_LEN) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd1;
            state_d     = HUNT;
          end else begin
            pay_idx_d = 8'd0;
            state_d   = PAYLOAD;
`ifdef FRAME_CHECKSUM_EN
            sum_d     = r_data;
`endif
          end
        end
        PAYLOAD: begin
          pay_valid_d = 1'b1;
          pay_data_d  = r_data;
`ifdef FRAME_CHECKSUM_EN
          sum_d       = sum_q + r_data;
          if (pay_idx_q + 8'd1 == len_q) state_d = CSUM;
`else
          if (pay_idx_q + 8'd1 == len_q) begin
            frame_done_d = 1'b1;
            state_d      = HUNT;
          end
`endif
        end
`ifdef FRAME_CHECKSUM_EN
        CSUM: begin
          sum_d = sum_q + r_data;
          if (sum_q + r_data == 8'd0) begin
            frame_done_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd2;
          end
          state_d = HUNT;
        end
`endif
        default: state_d = HUNT;
      endcase
    end else if (state_q != HUNT && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      frame_err_d = 1'b1;
      err_code_d  = 2'd3;
      state_d     = HUNT;
    end

    if (state_d == HUNT) tmo_d = '0;
    busy_d = (state_d != HUNT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HUNT;
      rd_q         <= 1'b0;
      pay_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      pay_data_q   <= 8'd0;
      pay_idx_q    <= 8'd0;
      len_q        <= 8'd0;
      err_code_q   <= 2'd0;
      tmo_q        <= '0;
`ifdef FRAME_CHECKSUM_EN
      sum_q        <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      rd_q         <= rd_d;
      pay_valid_q  <= pay_valid_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
      pay_data_q   <= pay_data_d;
      pay_idx_q    <= pay_idx_d;
      len_q        <= len_d;
      err_code_q   <= err_code_d;
      tmo_q        <= tmo_d;
`ifdef FRAME_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign rd         = rd_q;
  assign pay_data   = pay_data_q;
  assign pay_valid  = pay_valid_q;
  assign pay_idx    = pay_idx_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: FIFO model feeding bytes, frame-buffer reference model, per-cycle compare.
module tb_uart_frame_rx;
  localparam int unsigned MAXL = 16;
  localparam int unsigned TMO  = 50;
  localparam logic [7:0]  SYNC = 8'hAA;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'd0;
  logic       rd, pay_valid, frame_done, frame_err, busy;
  logic [7:0] pay_data, pay_idx;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  uart_frame_rx #(.SYNC_BYTE(SYNC), .MAX_LEN(MAXL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd(rd),
    .pay_data(pay_data), .pay_valid(pay_valid), .pay_idx(pay_idx),
    .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code), .busy(busy)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] q[$];
  logic [7:0] frm[$];
  logic       rst_req = 1'b1;
  bit         stall_en = 1'b0;
  bit         pop_pending = 1'b0;
  bit         armed = 1'b0;
  int         idle = 0;
  int         cyc = 0;

  logic       e_rd = 1'b0, e_pv = 1'b0, e_done = 1'b0, e_err = 1'b0, e_busy = 1'b0;
  logic [7:0] e_data = 8'd0, e_idx = 8'd0;
  logic [1:0] e_code = 2'd0;

  int n_done = 0, n_err = 0, n_pv = 0, n_both = 0;
  int pv_cyc = 0, err_cyc = 0;
  logic [7:0] pv_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Compare, then act as FIFO and reference model for the next cycle.
  always @(negedge clk) begin : model
    logic [7:0] b;
    bit cap, nrd, pv, dn, er;
    int sum;
    cyc++;
    if (armed) begin
      chk("rd",         32'(rd),         32'(e_rd));
      chk("pay_valid",  32'(pay_valid),  32'(e_pv));
      chk("frame_done", 32'(frame_done), 32'(e_done));
      chk("frame_err",  32'(frame_err),  32'(e_err));
      chk("busy",       32'(busy),       32'(e_busy));
      chk("pay_data",   32'(pay_data),   32'(e_data));
      chk("pay_idx",    32'(pay_idx),    32'(e_idx));
      chk("err_code",   32'(err_code),   32'(e_code));
      if (pay_valid === 1'b1) begin n_pv++; pv_log.push_back(pay_data); pv_cyc = cyc; end
      if (frame_done === 1'b1) n_done++;
      if (frame_err === 1'b1) begin n_err++; err_cyc = cyc; end
      if (pay_valid === 1'b1 && frame_done === 1'b1) n_both++;
    end
    if (pop_pending && q.size() > 0) void'(q.pop_front());
    pop_pending = 1'b0;
    reset = rst_req;
    if (rst_req) begin
      q.delete(); frm.delete(); idle = 0;
      rx_empty = 1'b1; r_data = 8'd0;
      e_rd = 0; e_pv = 0; e_done = 0; e_err = 0; e_busy = 0;
      e_data = 8'd0; e_idx = 8'd0; e_code = 2'd0;
      armed = 1'b1;
    end else begin
      rx_empty = (q.size() == 0) || (stall_en && !e_rd && $urandom_range(0, 3) == 0);
      r_data   = (q.size() > 0) ? q[0] : 8'($urandom);
      cap = e_rd; b = r_data;
      nrd = !rx_empty && !e_rd;
      pv = 0; dn = 0; er = 0;
      if (e_pv) e_idx = e_idx + 8'd1;
      if (cap) begin
        pop_pending = 1'b1;
        idle = 0;
        if (frm.size() == 0) begin
          if (b == SYNC) frm.push_back(b);
        end else if (frm.size() == 1) begin
          if (b == 8'd0 || int'(b) > int'(MAXL)) begin
            er = 1; e_code = 2'd1; frm.delete();
          end else begin
            frm.push_back(b); e_idx = 8'd0;
          end
        end else begin
          frm.push_back(b);
          if (frm.size() <= int'(frm[1]) + 2) begin
            pv = 1; e_data = b; e_idx = 8'(frm.size() - 3);
`ifndef FRAME_CHECKSUM_EN
            if (frm.size() == int'(frm[1]) + 2) begin dn = 1; frm.delete(); end
`endif
          end else begin
            sum = 0;
            for (int i = 1; i < frm.size(); i++) sum += int'(frm[i]);
            if (sum % 256 == 0) dn = 1;
            else begin er = 1; e_code = 2'd2; end
            frm.delete();
          end
        end
      end else if (frm.size() > 0) begin
        idle++;
        if (idle == int'(TMO)) begin er = 1; e_code = 2'd3; frm.delete(); end
      end
      e_rd = nrd; e_pv = pv; e_done = dn; e_err = er;
      e_busy = (frm.size() > 0);
    end
  end

  task automatic drain();
    int k;
    k = 0;
    while ((q.size() != 0 || pop_pending) && k < 3000) begin @(posedge clk); k++; end
    if (k >= 3000) begin
      fails++; tests++;
      $display("FAIL drain: queue not consumed, %0d bytes left, expected 0", q.size());
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
  endtask

  int d0, e0, p0, b0, len, bad;
  logic [7:0] s;

  initial begin
    repeat (3) @(posedge clk);
    rst_req = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err_code", 32'(err_code), 32'd0);

    // three-byte frame with a correct checksum
    d0 = n_done; e0 = n_err; p0 = n_pv; pv_log.delete();
    push(8'hAA); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h97);
    drain();
    chk("f1_done", 32'(n_done - d0), 32'd1);
    chk("f1_err", 32'(n_err - e0), 32'd0);
    chk("f1_pv", 32'(n_pv - p0), 32'd3);
    if (pv_log.size() == 3) begin
      chk("f1_b0", 32'(pv_log[0]), 32'h11);
      chk("f1_b1", 32'(pv_log[1]), 32'h22);
      chk("f1_b2", 32'(pv_log[2]), 32'h33);
    end else begin
      chk("f1_log_size", 32'(pv_log.size()), 32'd3);
    end

    // leading junk discarded
    d0 = n_done; e0 = n_err;
    push(8'h55); push(8'h00); push(8'hAA); push(8'h02); push(8'h01); push(8'h02); push(8'hFB);
    drain();
    chk("f2_done", 32'(n_done - d0), 32'd1);
    chk("f2_err", 32'(n_err - e0), 32'd0);

    // wrong checksum
    d0 = n_done; e0 = n_err;
    push(8'hAA); push(8'h02); push(8'h01); push(8'h02); push(8'h00);
    drain();
`ifdef FRAME_CHECKSUM_EN
    chk("f3_err", 32'(n_err - e0), 32'd1);
    chk("f3_done", 32'(n_done - d0), 32'd0);
    chk("f3_code", 32'(err_code), 32'd2);
`else
    chk("f3_err", 32'(n_err - e0), 32'd0);
    chk("f3_done", 32'(n_done - d0), 32'd1);
`endif

    // zero and oversize lengths
    d0 = n_done; e0 = n_err;
    push(8'hAA); push(8'h00); push(8'hAA); push(8'h11);
    drain();
    chk("f4_err", 32'(n_err - e0), 32'd2);
    chk("f4_code", 32'(err_code), 32'd1);
    chk("f4_busy", 32'(busy), 32'd0);

    // timeout mid-payload
    e0 = n_err;
    push(8'hAA); push(8'h03); push(8'h11);
    drain();
    repeat (60) @(posedge clk); #1;
    chk("f5_err", 32'(n_err - e0), 32'd1);
    chk("f5_delay", 32'(err_cyc - pv_cyc), 32'(TMO));
    chk("f5_code", 32'(err_code), 32'd3);
    chk("f5_busy", 32'(busy), 32'd0);

    // single-byte frame: pay_valid and frame_done coincide only without checksum
    d0 = n_done; b0 = n_both;
    push(8'hAA); push(8'h01); push(8'h5A);
`ifdef FRAME_CHECKSUM_EN
    push(8'hA5);
`endif
    drain();
    chk("f6_done", 32'(n_done - d0), 32'd1);
`ifdef FRAME_CHECKSUM_EN
    chk("f6_both", 32'(n_both - b0), 32'd0);
`else
    chk("f6_both", 32'(n_both - b0), 32'd1);
`endif

    // reset mid-frame
    e0 = n_err;
    push(8'hAA); push(8'h05); push(8'h01); push(8'h02);
    drain();
    rst_req = 1'b1;
    repeat (2) @(posedge clk);
    rst_req = 1'b0;
    #1;
    chk("f7_err", 32'(n_err - e0), 32'd0);
    chk("f7_busy", 32'(busy), 32'd0);
    chk("f7_pay_data", 32'(pay_data), 32'd0);
    chk("f7_pay_idx", 32'(pay_idx), 32'd0);
    chk("f7_err_code", 32'(err_code), 32'd0);
    chk("f7_rd", 32'(rd), 32'd0);

    // randomized frames with stalls, junk, bad lengths and bad checksums
    stall_en = 1'b1;
    for (int f = 0; f < 60; f++) begin
      for (int j = $urandom_range(0, 2); j > 0; j--) push(8'($urandom));
      bad = $urandom_range(0, 9);
      len = (bad == 0) ? ($urandom_range(0, 1) == 0 ? 0 : $urandom_range(MAXL + 1, 255))
                       : $urandom_range(1, MAXL);
      push(SYNC); push(8'(len));
      if (len >= 1 && len <= int'(MAXL)) begin
        s = 8'(len);
        for (int j = 0; j < len; j++) begin
          logic [7:0] v;
          v = 8'($urandom);
          push(v); s = s + v;
        end
`ifdef FRAME_CHECKSUM_EN
        push((bad == 1) ? 8'(8'd0 - s + 8'd1) : 8'(8'd0 - s));
`endif
      end
    end
    drain();
    repeat (70) @(posedge clk);
    stall_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
